pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: sequences instruction fetch, next-PC selection and redirect kill.
// Optional build macro PC_FETCH_DELAY_SLOT_EN delivers the in-flight instruction as a delay slot.
module pc_fetch_ctrl #(
  parameter int unsigned           WIDTH        = 32,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [WIDTH-1:0]      EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pc_d,
  output logic             pc_en,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  output logic             fetch_valid,
  output logic             fetch_kill
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
  // Encoded so that a larger value means higher redirect priority.
  typedef enum logic [1:0] {K_NONE, K_JUMP, K_BRANCH, K_EXC} kind_t;

  state_t           state, state_nx;
  logic             pend_valid, pend_valid_nx;
  kind_t            pend_kind, pend_kind_nx;
  logic [WIDTH-1:0] pend_target, pend_target_nx;

  logic             br, jp, kill;
  kind_t            new_kind;
  logic [WIDTH-1:0] new_target, next_pc;

  always_comb begin
    br = branch_taken & ~stall;
    jp = jump & ~stall;

    new_kind   = K_NONE;
    new_target = pc_q + WIDTH'(4);
    if (exc) begin
      new_kind   = K_EXC;
      new_target = EXC_VECTOR;
    end else if (br) begin
      new_kind   = K_BRANCH;
      new_target = branch_target;
    end else if (jp) begin
      new_kind   = K_JUMP;
      new_target = jump_target;
    end

    if (new_kind != K_NONE) next_pc = new_target;
    else if (pend_valid)    next_pc = pend_target;
    else                    next_pc = pc_q + WIDTH'(4);

`ifdef PC_FETCH_DELAY_SLOT_EN
    kill = exc | (pend_valid & (pend_kind == K_EXC));
`else
    kill = exc | br | jp | pend_valid;
`endif
  end

  always_comb begin
    state_nx       = state;
    pend_valid_nx  = pend_valid;
    pend_kind_nx   = pend_kind;
    pend_target_nx = pend_target;
    pc_en          = 1'b0;
    pc_d           = next_pc;
    imem_req       = 1'b0;
    fetch_valid    = 1'b0;
    fetch_kill     = 1'b0;

    case (state)
      BOOT: begin
        pc_en    = 1'b1;
        pc_d     = RESET_VECTOR;
        state_nx = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // A killed return is discarded, so the redirect loads even under stall.
          if (kill) begin
            fetch_kill = 1'b1;
            pc_en      = 1'b1;
          end else begin
            fetch_valid = 1'b1;
            if (stall) state_nx = HOLD;
            else       pc_en    = 1'b1;
          end
        end else if ((new_kind != K_NONE) && (!pend_valid || (new_kind >= pend_kind))) begin
          pend_valid_nx  = 1'b1;
          pend_kind_nx   = new_kind;
          pend_target_nx = new_target;
        end
      end
      HOLD: begin
        fetch_valid = 1'b1;
        if (exc) begin
          fetch_valid = 1'b0;
          fetch_kill  = 1'b1;
          pc_en       = 1'b1;
          state_nx    = FETCH;
        end else if (!stall) begin
          pc_en    = 1'b1;
          state_nx = FETCH;
        end
      end
      default: state_nx = BOOT;
    endcase

    if (pc_en) begin
      pend_valid_nx = 1'b0;
      pend_kind_nx  = K_NONE;
    end

    if (rst) begin
      pc_en       = 1'b0;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
      fetch_kill  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_kind   <= K_NONE;
      pend_target <= '0;
    end else begin
      state       <= state_nx;
      pend_valid  <= pend_valid_nx;
      pend_kind   <= pend_kind_nx;
      pend_target <= pend_target_nx;
    end
  end

endmodule
